// File: rtl/swd_host_ctrl.sv
// SWD host transaction engine: serialises DP/AP single-word requests and the
// JTAG-to-SWD wake sequence onto SWCLK/SWDIO, retries WAIT, reports ACK/data.
module swd_host_ctrl #(
  parameter int DIV_HALF    = 24,
  parameter int IDLE_CYCLES = 2,
  parameter int MAX_RETRY   = 7,
  parameter int LRST_ONES   = 56
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_lrst,
  input  logic        req_apndp,
  input  logic        req_rnw,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_ack,
  output logic [31:0] rsp_rdata,
  output logic        rsp_perr,
  output logic        SWCLK,
  output logic        swdio_o,
  output logic        swdio_oe,
  input  logic        swdio_i
);

  localparam int CNT_W = $clog2(2 * LRST_ONES + 16 + IDLE_CYCLES + 33);
  localparam int DIV_W = $clog2(DIV_HALF);
  localparam int RTY_W = ($clog2(MAX_RETRY + 1) > 3) ? $clog2(MAX_RETRY + 1) : 3;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_HALF - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0] LR_SEL_LO = CNT_W'(LRST_ONES);
  localparam logic [CNT_W-1:0] LR_SEL_HI = CNT_W'(LRST_ONES + 16);
  localparam logic [CNT_W-1:0] LR_LAST   = CNT_W'(2 * LRST_ONES + 15);
  localparam logic [CNT_W-1:0] IC_LAST   = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [15:0]      SEL_WORD  = 16'hE79E;
  localparam logic [2:0]       ACK_OK    = 3'b001;
  localparam logic [2:0]       ACK_WAIT  = 3'b010;

  typedef enum logic [3:0] {
    S_IDLE, S_LRST, S_HDR, S_TRN1, S_ACK, S_RDATA, S_RPAR,
    S_TRN2, S_WDATA, S_WPAR, S_IDLEC, S_RESP
  } state_t;

  state_t             state;
  state_t             nxt_state;
  state_t             idle_next;
  state_t             post_work;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   nxt_idx;
  logic [DIV_W-1:0]   div_cnt;
  logic [RTY_W-1:0]   rty_cnt;

  logic               t_lrst;
  logic               t_apndp;
  logic               t_rnw;
  logic [1:0]         t_addr;
  logic [31:0]        t_wdata;
  logic [2:0]         ack_sr;
  logic [31:0]        rdata_sr;
  logic               par_bit;

  logic               busy;
  logic               tick;
  logic               rise;
  logic               accept;
  logic               ack_ok;
  logic               retry;
  logic               rd_ok;
  logic [7:0]         hdr_w;

  function automatic logic [7:0] make_hdr(input logic apndp, input logic rnw,
                                          input logic [1:0] addr);
    return {1'b1, 1'b0, addr[1] ^ addr[0] ^ apndp ^ rnw, addr[1], addr[0], rnw, apndp, 1'b1};
  endfunction

  function automatic logic lrst_bit(input logic [CNT_W-1:0] idx);
    if (idx < LR_SEL_LO)      return 1'b1;
    else if (idx < LR_SEL_HI) return SEL_WORD[4'(idx - LR_SEL_LO)];
    else                      return 1'b1;
  endfunction

  // {oe, o} presented on SWDIO for bit idx of state st
  function automatic logic [1:0] bit_drive(input state_t st, input logic [CNT_W-1:0] idx,
                                           input logic [7:0] hdr, input logic [31:0] wd);
    case (st)
      S_LRST:  return {1'b1, lrst_bit(idx)};
      S_HDR:   return {1'b1, hdr[idx[2:0]]};
      S_WDATA: return {1'b1, wd[idx[4:0]]};
      S_WPAR:  return {1'b1, ^wd};
      S_IDLEC: return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] last_idx(input state_t st);
    case (st)
      S_LRST:           return LR_LAST;
      S_HDR:            return CNT_W'(7);
      S_ACK:            return CNT_W'(2);
      S_RDATA, S_WDATA: return CNT_W'(31);
      S_IDLEC:          return IC_LAST;
      default:          return '0;
    endcase
  endfunction

  assign busy      = (state != S_IDLE) && (state != S_RESP);
  assign tick      = (div_cnt == DIV_LAST);
  assign rise      = busy && tick && !SWCLK;
  assign accept    = req_valid && req_ready;
  assign ack_ok    = (ack_sr == ACK_OK);
  assign retry     = !t_lrst && (ack_sr == ACK_WAIT) && (rty_cnt < RTY_MAX);
  assign rd_ok     = !t_lrst && t_rnw && ack_ok;
  assign hdr_w     = make_hdr(t_apndp, t_rnw, t_addr);
  assign idle_next = retry ? S_HDR : S_RESP;
  assign post_work = (IDLE_CYCLES > 0) ? S_IDLEC : idle_next;

  // Bit sequencing: what follows the bit that is just ending
  always_comb begin
    nxt_state = state;
    nxt_idx   = bit_cnt + 1'b1;
    if (bit_cnt == last_idx(state)) begin
      nxt_idx = '0;
      case (state)
        S_LRST:  nxt_state = post_work;
        S_HDR:   nxt_state = S_TRN1;
        S_TRN1:  nxt_state = S_ACK;
        S_ACK:   nxt_state = (ack_ok && t_rnw) ? S_RDATA : S_TRN2;
        S_RDATA: nxt_state = S_RPAR;
        S_RPAR:  nxt_state = S_TRN2;
        S_TRN2:  nxt_state = (ack_ok && !t_rnw) ? S_WDATA : post_work;
        S_WDATA: nxt_state = S_WPAR;
        S_WPAR:  nxt_state = post_work;
        S_IDLEC: nxt_state = idle_next;
        default: nxt_state = state;
      endcase
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      rty_cnt   <= '0;
      SWCLK     <= 1'b0;
      swdio_o   <= 1'b1;
      swdio_oe  <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_ack   <= 3'b000;
      rsp_rdata <= '0;
      rsp_perr  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          SWCLK   <= 1'b0;
          if (accept) begin
            state     <= req_lrst ? S_LRST : S_HDR;
            bit_cnt   <= '0;
            rty_cnt   <= '0;
            req_ready <= 1'b0;
            {swdio_oe, swdio_o} <= bit_drive(req_lrst ? S_LRST : S_HDR, '0,
                                             make_hdr(req_apndp, req_rnw, req_addr),
                                             req_wdata);
          end
        end
        S_RESP: begin
          div_cnt <= '0;
          SWCLK   <= 1'b0;
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          if (!tick) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            SWCLK   <= !SWCLK;
            // Falling SWCLK edge closes a bit and presents the next one
            if (SWCLK) begin
              state   <= nxt_state;
              bit_cnt <= nxt_idx;
              {swdio_oe, swdio_o} <= bit_drive(nxt_state, nxt_idx, hdr_w, t_wdata);
              if (nxt_state == S_HDR && state != S_HDR)
                rty_cnt <= rty_cnt + 1'b1;
              if (nxt_state == S_RESP) begin
                rsp_valid <= 1'b1;
                rsp_ack   <= t_lrst ? ACK_OK : ack_sr;
                rsp_rdata <= rd_ok ? rdata_sr : '0;
                rsp_perr  <= rd_ok && ((^rdata_sr) != par_bit);
              end
            end
          end
        end
      endcase
    end
  end

  // Request capture and target-bit sampling on the rising SWCLK edge
  always_ff @(posedge clkin) begin
    if (accept) begin
      t_lrst  <= req_lrst;
      t_apndp <= req_apndp;
      t_rnw   <= req_rnw;
      t_addr  <= req_addr;
      t_wdata <= req_wdata;
    end
    if (rise) begin
      case (state)
        S_ACK:   ack_sr[bit_cnt[1:0]]   <= swdio_i;
        S_RDATA: rdata_sr[bit_cnt[4:0]] <= swdio_i;
        S_RPAR:  par_bit                <= swdio_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_swd_host_ctrl.sv
// Directed bench for swd_host_ctrl: a scripted SWD target answers each bit
// and every scenario task checks header bits, line activity and the response.
module tb_swd_host_ctrl;

  localparam int DH = 4;
  localparam int IC = 2;
  localparam int MR = 7;
  localparam int LO = 56;

  logic        clkin = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_lrst = 1'b0;
  logic        req_apndp = 1'b0;
  logic        req_rnw = 1'b0;
  logic [1:0]  req_addr = 2'b00;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;
  logic        rsp_perr;
  logic        SWCLK;
  logic        swdio_o;
  logic        swdio_oe;
  logic        swdio_i = 1'b1;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  swd_host_ctrl #(.DIV_HALF(DH), .IDLE_CYCLES(IC), .MAX_RETRY(MR), .LRST_ONES(LO)) dut (
    .clkin(clkin), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_lrst(req_lrst),
    .req_apndp(req_apndp), .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ack(rsp_ack),
    .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr),
    .SWCLK(SWCLK), .swdio_o(swdio_o), .swdio_oe(swdio_oe), .swdio_i(swdio_i)
  );

  always #5 clkin = ~clkin;
  always @(posedge SWCLK) edge_cnt <= edge_cnt + 1;

  task automatic wait_level(input logic lvl);
    int n;
    n = 0;
    while (SWCLK !== lvl && n < 8 * DH + 20) begin
      @(negedge clkin);
      n++;
    end
    if (SWCLK !== lvl) begin
      errors++;
      $display("FAIL swclk_timeout: SWCLK=%b required %b", SWCLK, lvl);
      $fatal(1, "SWCLK stalled, aborting");
    end
  endtask

  // One SWD bit: target drives swdio_i (if tdrv) and host pins are captured in the high phase
  task automatic swd_bit(input logic tdrv, input logic tval, output logic ho, output logic hoe);
    swdio_i = tdrv ? tval : 1'b1;
    wait_level(1'b1);
    ho  = swdio_o;
    hoe = swdio_oe;
    wait_level(1'b0);
  endtask

  task automatic attempt(input logic [2:0] ack, input logic rnw, input logic [31:0] rd,
                         input logic flip, output logic [7:0] hdr, output logic [31:0] wd,
                         output logic wp, output int bad);
    logic o, oe;
    bad = 0; wd = '0; wp = 1'b0; hdr = '0;
    for (int i = 0; i < 8; i++) begin
      swd_bit(1'b0, 1'b0, o, oe); hdr[i] = o; if (!oe) bad++;
    end
    swd_bit(1'b0, 1'b0, o, oe); if (oe) bad++;
    for (int i = 0; i < 3; i++) begin
      swd_bit(1'b1, ack[i], o, oe); if (oe) bad++;
    end
    if (ack == 3'b001 && rnw) begin
      for (int i = 0; i < 32; i++) begin
        swd_bit(1'b1, rd[i], o, oe); if (oe) bad++;
      end
      swd_bit(1'b1, (^rd) ^ flip, o, oe); if (oe) bad++;
      swd_bit(1'b0, 1'b0, o, oe); if (oe) bad++;
    end else if (ack == 3'b001) begin
      swd_bit(1'b0, 1'b0, o, oe); if (oe) bad++;
      for (int i = 0; i < 32; i++) begin
        swd_bit(1'b0, 1'b0, o, oe); wd[i] = o; if (!oe) bad++;
      end
      swd_bit(1'b0, 1'b0, o, oe); wp = o; if (!oe) bad++;
    end else begin
      swd_bit(1'b0, 1'b0, o, oe); if (oe) bad++;
    end
    for (int i = 0; i < IC; i++) begin
      swd_bit(1'b0, 1'b0, o, oe); if (!oe || o) bad++;
    end
  endtask

  task automatic send_req(input logic lrst, input logic apndp, input logic rnw,
                          input logic [1:0] addr, input logic [31:0] wd);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clkin); n++; end
    req_lrst = lrst; req_apndp = apndp; req_rnw = rnw; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clkin);
    req_valid = 1'b0;
    req_lrst  = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clkin); n++; end
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
      $fatal(1, "no response, aborting");
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clkin);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clkin);
    checks++;
    if ({SWCLK, swdio_o, swdio_oe, req_ready, rsp_valid, rsp_ack, rsp_perr} !== 9'b0_1_0_1_0_000_0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required %b",
               {SWCLK, swdio_o, swdio_oe, req_ready, rsp_valid, rsp_ack, rsp_perr}, 9'b0_1_0_1_0_000_0);
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h required 0", rsp_rdata);
    end
    reset = 1'b0;
    @(negedge clkin);
  endtask

  task automatic test_lrst();
    logic [15:0] sel;
    logic o, oe, e;
    int bad, e0;
    sel = 16'hE79E; bad = 0; e0 = edge_cnt;
    send_req(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    for (int i = 0; i < 2 * LO + 16 + IC; i++) begin
      swd_bit(1'b0, 1'b0, o, oe);
      if (i < LO) e = 1'b1;
      else if (i < LO + 16) e = sel[i - LO];
      else if (i < 2 * LO + 16) e = 1'b1;
      else e = 1'b0;
      if (o !== e || oe !== 1'b1) bad++;
    end
    wait_rsp();
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL lrst_bits: %0d wrong bits required 0", bad); end
    checks++;
    if (edge_cnt - e0 !== 130) begin errors++; $display("FAIL lrst_edges: got %0d required 130", edge_cnt - e0); end
    checks++;
    if (rsp_ack !== 3'b001) begin errors++; $display("FAIL lrst_ack: got %b required 001", rsp_ack); end
    release_rsp();
  endtask

  task automatic test_write_select();
    logic [7:0] hdr; logic [31:0] wd; logic wp; int bad, e0;
    e0 = edge_cnt;
    send_req(1'b0, 1'b0, 1'b0, 2'b10, 32'h0);
    attempt(3'b001, 1'b0, 32'h0, 1'b0, hdr, wd, wp, bad);
    wait_rsp();
    checks++;
    if (hdr !== 8'hB1) begin errors++; $display("FAIL wsel_hdr: got %h required b1", hdr); end
    checks++;
    if ({wd, wp} !== 33'h0) begin errors++; $display("FAIL wsel_data: got %h/%b required 0/0", wd, wp); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL wsel_line: %0d wrong bits required 0", bad); end
    checks++;
    if (edge_cnt - e0 !== 48) begin errors++; $display("FAIL wsel_edges: got %0d required 48", edge_cnt - e0); end
    repeat (3) @(negedge clkin);
    checks++;
    if ({rsp_valid, rsp_ack, rsp_perr, req_ready, SWCLK} !== 7'b1_001_0_0_0) begin
      errors++; $display("FAIL wsel_rsp_hold: got %b required 1001000", {rsp_valid, rsp_ack, rsp_perr, req_ready, SWCLK});
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL wsel_rdata: got %h required 0", rsp_rdata); end
    release_rsp();
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL wsel_release: got %b required 10", {req_ready, rsp_valid});
    end
  endtask

  task automatic test_read_dpidr();
    logic [7:0] hdr; logic [31:0] wd; logic wp; int bad, e0;
    e0 = edge_cnt;
    send_req(1'b0, 1'b0, 1'b1, 2'b00, 32'h0);
    attempt(3'b001, 1'b1, 32'h2BA01477, 1'b0, hdr, wd, wp, bad);
    wait_rsp();
    checks++;
    if (hdr !== 8'hA5) begin errors++; $display("FAIL dpidr_hdr: got %h required a5", hdr); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL dpidr_line: %0d wrong bits required 0", bad); end
    checks++;
    if ({rsp_rdata, rsp_ack, rsp_perr} !== {32'h2BA01477, 3'b001, 1'b0}) begin
      errors++; $display("FAIL dpidr_rsp: got %h/%b/%b required 2ba01477/001/0", rsp_rdata, rsp_ack, rsp_perr);
    end
    checks++;
    if (edge_cnt - e0 !== 48) begin errors++; $display("FAIL dpidr_edges: got %0d required 48", edge_cnt - e0); end
    release_rsp();
  endtask

  task automatic test_wait_retry();
    logic [7:0] hdr; logic [31:0] wd; logic wp; int bad, e0;
    e0 = edge_cnt;
    send_req(1'b0, 1'b1, 1'b0, 2'b00, 32'h12345678);
    for (int a = 0; a < 2; a++) begin
      attempt(3'b010, 1'b0, 32'h0, 1'b0, hdr, wd, wp, bad);
      checks++;
      if ({hdr, bad[3:0]} !== {8'hA3, 4'h0}) begin
        errors++; $display("FAIL retry_hdr%0d: got %h bad %0d required a3 bad 0", a, hdr, bad);
      end
    end
    attempt(3'b001, 1'b0, 32'h0, 1'b0, hdr, wd, wp, bad);
    wait_rsp();
    checks++;
    if ({hdr, wd, wp} !== {8'hA3, 32'h12345678, 1'b1}) begin
      errors++; $display("FAIL retry_write: got %h %h %b required a3 12345678 1", hdr, wd, wp);
    end
    checks++;
    if (edge_cnt - e0 !== 78) begin errors++; $display("FAIL retry_edges: got %0d required 78", edge_cnt - e0); end
    checks++;
    if ({rsp_ack, rsp_perr} !== 4'b0010) begin
      errors++; $display("FAIL retry_ack: got %b/%b required 001/0", rsp_ack, rsp_perr);
    end
    release_rsp();
  endtask

  task automatic test_wait_exhaust();
    logic [7:0] hdr; logic [31:0] wd; logic wp; int bad, nbad, e0;
    e0 = edge_cnt; nbad = 0;
    send_req(1'b0, 1'b1, 1'b1, 2'b01, 32'h0);
    for (int a = 0; a < MR + 1; a++) begin
      attempt(3'b010, 1'b1, 32'h0, 1'b0, hdr, wd, wp, bad);
      if (hdr !== 8'hAF || bad != 0) nbad++;
    end
    wait_rsp();
    checks++;
    if (nbad !== 0) begin errors++; $display("FAIL exhaust_hdrs: %0d bad attempts required 0", nbad); end
    checks++;
    if (edge_cnt - e0 !== 120) begin errors++; $display("FAIL exhaust_edges: got %0d required 120", edge_cnt - e0); end
    checks++;
    if ({rsp_ack, rsp_rdata, rsp_perr} !== {3'b010, 32'h0, 1'b0}) begin
      errors++; $display("FAIL exhaust_rsp: got %b/%h/%b required 010/0/0", rsp_ack, rsp_rdata, rsp_perr);
    end
    release_rsp();
  endtask

  task automatic test_parity_fault();
    logic [7:0] hdr; logic [31:0] wd; logic wp; int bad, e0;
    send_req(1'b0, 1'b0, 1'b1, 2'b11, 32'h0);
    attempt(3'b001, 1'b1, 32'hDEADBEEF, 1'b1, hdr, wd, wp, bad);
    wait_rsp();
    checks++;
    if (hdr !== 8'hBD) begin errors++; $display("FAIL perr_hdr: got %h required bd", hdr); end
    checks++;
    if ({rsp_rdata, rsp_ack, rsp_perr} !== {32'hDEADBEEF, 3'b001, 1'b1}) begin
      errors++; $display("FAIL perr_rsp: got %h/%b/%b required deadbeef/001/1", rsp_rdata, rsp_ack, rsp_perr);
    end
    release_rsp();
    e0 = edge_cnt;
    send_req(1'b0, 1'b0, 1'b0, 2'b01, 32'hCAFEF00D);
    attempt(3'b100, 1'b0, 32'h0, 1'b0, hdr, wd, wp, bad);
    wait_rsp();
    checks++;
    if ({hdr, bad[3:0]} !== {8'hA9, 4'h0}) begin
      errors++; $display("FAIL fault_hdr: got %h bad %0d required a9 bad 0", hdr, bad);
    end
    checks++;
    if (edge_cnt - e0 !== 15) begin errors++; $display("FAIL fault_edges: got %0d required 15", edge_cnt - e0); end
    checks++;
    if ({rsp_ack, rsp_rdata, rsp_perr} !== {3'b100, 32'h0, 1'b0}) begin
      errors++; $display("FAIL fault_rsp: got %b/%h/%b required 100/0/0", rsp_ack, rsp_rdata, rsp_perr);
    end
    release_rsp();
  endtask

  task automatic test_back_to_back();
    logic [7:0] hdr; logic [31:0] wd; logic wp; int bad;
    send_req(1'b0, 1'b0, 1'b1, 2'b00, 32'h0);
    attempt(3'b001, 1'b1, 32'h00000001, 1'b0, hdr, wd, wp, bad);
    wait_rsp();
    checks++;
    if ({rsp_rdata, rsp_perr} !== {32'h1, 1'b0}) begin
      errors++; $display("FAIL b2b_first: got %h/%b required 00000001/0", rsp_rdata, rsp_perr);
    end
    rsp_ready = 1'b1;
    req_apndp = 1'b0; req_rnw = 1'b0; req_addr = 2'b01; req_wdata = 32'h000000FF;
    req_valid = 1'b1;
    @(negedge clkin);
    rsp_ready = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, SWCLK} !== 3'b100) begin
      errors++; $display("FAIL b2b_wait: got %b required 100", {req_ready, rsp_valid, SWCLK});
    end
    @(negedge clkin);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: req_ready=%b required 0", req_ready); end
    attempt(3'b001, 1'b0, 32'h0, 1'b0, hdr, wd, wp, bad);
    wait_rsp();
    checks++;
    if ({hdr, wd, wp, rsp_ack} !== {8'hA9, 32'h000000FF, 1'b0, 3'b001}) begin
      errors++; $display("FAIL b2b_second: got %h %h %b %b required a9 000000ff 0 001", hdr, wd, wp, rsp_ack);
    end
    release_rsp();
  endtask

  task automatic test_reset_abort();
    logic [7:0] hdr; logic [31:0] wd; logic wp; logic o, oe; int bad;
    send_req(1'b0, 1'b1, 1'b0, 2'b00, 32'hFFFFFFFF);
    for (int i = 0; i < 8; i++) swd_bit(1'b0, 1'b0, o, oe);
    swd_bit(1'b0, 1'b0, o, oe);
    for (int i = 0; i < 3; i++) swd_bit(1'b1, i == 0, o, oe);
    swd_bit(1'b0, 1'b0, o, oe);
    for (int i = 0; i < 10; i++) swd_bit(1'b0, 1'b0, o, oe);
    wait_level(1'b1);
    checks++;
    if ({swdio_oe, swdio_o} !== 2'b11) begin
      errors++; $display("FAIL abort_wbit10: got %b required 11", {swdio_oe, swdio_o});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({SWCLK, swdio_oe, req_ready, rsp_valid} !== 4'b0010) begin
      errors++; $display("FAIL abort_async: got %b required 0010", {SWCLK, swdio_oe, req_ready, rsp_valid});
    end
    @(negedge clkin);
    reset = 1'b0;
    repeat (2) @(negedge clkin);
    checks++;
    if ({SWCLK, swdio_oe, req_ready, rsp_valid} !== 4'b0010) begin
      errors++; $display("FAIL abort_idle: got %b required 0010", {SWCLK, swdio_oe, req_ready, rsp_valid});
    end
    send_req(1'b0, 1'b0, 1'b1, 2'b00, 32'h0);
    attempt(3'b001, 1'b1, 32'h2BA01477, 1'b0, hdr, wd, wp, bad);
    wait_rsp();
    checks++;
    if ({hdr, rsp_rdata, rsp_ack, rsp_perr} !== {8'hA5, 32'h2BA01477, 3'b001, 1'b0}) begin
      errors++; $display("FAIL abort_next: got %h %h %b %b required a5 2ba01477 001 0", hdr, rsp_rdata, rsp_ack, rsp_perr);
    end
    release_rsp();
  endtask

  initial begin
    test_reset();
    test_lrst();
    test_write_select();
    test_read_dpidr();
    test_wait_retry();
    test_wait_exhaust();
    test_parity_fault();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/swd_host_ctrl.md
Name: swd_host_ctrl

Overview:
- Synthesizable SWD host transaction engine.
- Turns single-word DP/AP read/write requests into SWD bit sequences on SWCLK/SWDIO: header, turnaround, ACK, data, parity.
- Retries on WAIT, returns ACK, read data and parity status over a valid/ready response port.
- Sits between an on-chip debug bridge and the SWD pads; also issues the line-reset / JTAG-to-SWD wake sequence.

Parameters:
DIV_HALF, 24, clkin cycles per SWCLK half-period (>=2)
IDLE_CYCLES, 2, driven-low SWCLK cycles appended after each transaction
MAX_RETRY, 7, WAIT retries before reporting WAIT to the requester
LRST_ONES, 56, high bits on each side of the JTAG-to-SWD select word

Ports:
clkin  input  1  clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  engine idle, accepts request
req_lrst  input  1  1 = wake/line-reset sequence only; other request fields ignored
req_apndp  input  1  0 = DP, 1 = AP
req_rnw  input  1  1 = read
req_addr  input  2  A[3:2]
req_wdata  input  32  write data
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed
rsp_ack  output  3  ACK as received; bit0 received first (OK = 3'b001, WAIT = 3'b010, FAULT = 3'b100)
rsp_rdata  output  32  read data (0 for writes)
rsp_perr  output  1  read parity mismatch
SWCLK  output  1  SWD clock
swdio_o  output  1  SWDIO drive value
swdio_oe  output  1  SWDIO drive enable
swdio_i  input  1  SWDIO pad input

Behaviour:
- Reset values (async): SWCLK=0, swdio_o=1, swdio_oe=0, req_ready=1, rsp_valid=0, rsp_ack=0, rsp_rdata=0, rsp_perr=0. FSM goes to IDLE.
- Reset asserted mid-transfer aborts immediately; no partial response.
- Bit timing:
  - Divider counts DIV_HALF clkin cycles per SWCLK phase; SWCLK is low when idle.
  - One SWD bit = one low phase + one high phase.
  - Host updates swdio_o/swdio_oe on the clkin edge that drives SWCLK low.
  - Host samples swdio_i on the edge that drives SWCLK high.
- Request handshake:
  - Accept on req_valid & req_ready.
  - req_ready=1 only in IDLE with rsp_valid=0; it deasserts the cycle after acceptance.
  - Request fields are registered at acceptance.
- FSM states: IDLE, LRST, HDR, TRN1, ACK, RDATA, RPAR, TRN2, WDATA, WPAR, IDLEC, RESP.
- LRST:
  - Drive LRST_ONES ones, then 16'hE79E LSB-first, then LRST_ONES ones, then IDLE_CYCLES zeros.
  - Then RESP with rsp_ack=3'b001.
- HDR: 8 bits, LSB-first: 1, APnDP, RnW, A2, A3, parity = A2^A3^APnDP^RnW, 0, 1.
- TRN1: 1 bit, swdio_oe=0.
- ACK: 3 bits sampled.
  - OK, read: RDATA (32 bits, LSB-first) -> RPAR (1 bit) -> TRN2 -> IDLEC.
  - OK, write: TRN2 -> WDATA (32 bits, LSB-first, oe=1) -> WPAR (^wdata) -> IDLEC.
  - WAIT with retry count < MAX_RETRY: TRN2 -> IDLEC -> HDR, same request, count+1.
  - WAIT with retry count = MAX_RETRY: TRN2 -> IDLEC -> RESP with ack WAIT.
  - FAULT or any other ACK value: TRN2 -> IDLEC -> RESP with that ack.
- TRN2 on reads keeps oe=0; host re-drives from IDLEC onward.
- IDLEC drives zeros with oe=1.
- rsp_perr = (^rdata) != sampled parity bit; rsp_perr=0 for writes and for non-OK ACKs.
- RESP:
  - rsp_valid held with stable fields until rsp_ready; then return to IDLE.
  - rsp_valid & rsp_ready in the same cycle a new req_valid arrives: the request waits one cycle, until req_ready rises.
- Retry counter is 3 bits wide minimum, clears on acceptance. MAX_RETRY=0 disables retries.
- SWCLK idles low in IDLE and RESP; divider is held at 0 there.

Test Plan:
- Line reset: req_lrst=1 -> 56 ones, 16'hE79E LSB-first, 56 ones, 2 zeros (130 SWCLK rising edges) -> rsp_ack=3'b001.
- Write DP SELECT: apndp=0, rnw=0, addr=2'b10, wdata=0, model ACK OK -> header bits 1,0,0,0,1,1,0,1 -> 32 zeros, parity 0 -> rsp_ack=3'b001, rsp_perr=0.
- Read DPIDR: addr=0, model returns 32'h2BA01477 with correct parity -> header 8'hA5 order -> rsp_rdata=32'h2BA01477, rsp_perr=0.
- WAIT x2 then OK on AP write -> exactly 3 headers observed, single response with ack=3'b001; WAIT x8 -> 8 headers, rsp_ack=3'b010.
- Read with flipped parity -> rsp_perr=1, data still returned. FAULT ACK -> no data phase, rsp_ack=3'b100.
- Reset asserted during WDATA bit 10 -> next clkin: SWCLK=0, swdio_oe=0, req_ready=1, rsp_valid=0; following request completes normally.
